// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: arbitrates one-cycle play requests for sounds 1..3
// onto the single shared playback engine. Sound 3 has the highest priority.
// A higher-priority request preempts the current sound. Any other request is
// held in a one-bit-per-sound pending mask until the engine is free.
//
// Handshake: req/stop are single-cycle strobes with no backpressure; the
// engine is started by a one-cycle snd_play strobe and reports progress only
// through the level signal snd_active.
module sfx_scheduler #(
    parameter int GAP_CYCLES  = 1000,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       stop,
    input  logic       snd_active,
    output logic       snd_play,
    output logic [1:0] snd_sel,
    output logic       busy,
    output logic [2:0] pending,
    output logic       timeout_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int AW = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] arm_q, arm_d;
    logic          play_d;
    logic [1:0]    sel_d;
    logic [2:0]    pend_d;
    logic          busy_d;
    logic          terr_d;

    logic [2:0]    req_all;
    logic [1:0]    grant;
    logic          active_state;
    logic          launch;
    logic          arm_expire;

    // Sound number (1..3) of the highest set bit; 0 when nothing is set.
    function automatic logic [1:0] top_idx(input logic [2:0] v);
        if (v[2])      return 2'd3;
        else if (v[1]) return 2'd2;
        else if (v[0]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Pending-mask bit belonging to a sound number.
    function automatic logic [2:0] idx_bit(input logic [1:0] s);
        case (s)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Pending bits are always at or below the current sound while one is
    // playing, so req|pending can also drive preemption. A preempting request
    // that arrives during the trigger cycle is parked in pending. It then
    // fires one cycle later, which keeps snd_play from ever being high two
    // cycles in a row.
    assign req_all      = req | pending;
    assign grant        = top_idx(req_all);
    assign active_state = (state_q == ARM) || (state_q == PLAY);
    assign launch       = !stop &&
                          (((state_q == IDLE) && (grant != 2'd0)) ||
                           (active_state && !snd_play && (grant > snd_sel)));
    assign arm_expire   = !stop && (state_q == ARM) && !launch &&
                          !snd_active && (arm_q == ARM_LAST);

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            arm_q       <= '0;
            snd_play    <= 1'b0;
            snd_sel     <= 2'd0;
            busy        <= 1'b0;
            pending     <= 3'b000;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            arm_q       <= arm_d;
            snd_play    <= play_d;
            snd_sel     <= sel_d;
            busy        <= busy_d;
            pending     <= pend_d;
            timeout_err <= terr_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        arm_d   = arm_q;
        if (stop) begin
            state_d = IDLE;
            gap_d   = '0;
            arm_d   = '0;
        end else if (launch) begin
            state_d = ARM;
            arm_d   = '0;
        end else begin
            case (state_q)
                ARM: begin
                    if (snd_active) begin
                        state_d = PLAY;
                    end else if (arm_expire) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        arm_d = arm_q + 1'b1;
                    end
                end
                PLAY: begin
                    if (!snd_active) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        play_d = launch;
        busy_d = (state_d != IDLE);
        terr_d = timeout_err | arm_expire;
        if (stop) begin
            sel_d  = 2'd0;
            pend_d = 3'b000;
        end else begin
            pend_d = req_all & ~(launch ? idx_bit(grant) : 3'b000);
            if (launch) begin
                sel_d = grant;
            end else if ((state_d == IDLE) || (state_d == GAP)) begin
                sel_d = 2'd0;
            end else begin
                sel_d = snd_sel;
            end
        end
    end

endmodule
